// File: rtl/dds_pkg.sv
// ---------------------------------------------------------------------------
// dds_pkg
// Shared definitions for the DDS sine generator front end: default widths,
// sweep-mode encodings and the sweep controller state type.
// ---------------------------------------------------------------------------
package dds_pkg;

    localparam int DDS_FTW_W   = 32;
    localparam int DDS_DWELL_W = 16;

    localparam logic [1:0] MODE_SINGLE = 2'b00;
    localparam logic [1:0] MODE_SAW    = 2'b01;
    localparam logic [1:0] MODE_TRI    = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        UP   = 2'b01,
        DOWN = 2'b10
    } sweep_state_e;

    // The unused encoding 2'b11 behaves as a single-shot sweep.
    function automatic logic mode_is_single(input logic [1:0] mode);
        return (mode == MODE_SINGLE) || (mode == 2'b11);
    endfunction

endpackage

// File: rtl/dwell_timer.sv
// ---------------------------------------------------------------------------
// dwell_timer
// Down-counter that measures how long the current tuning word is held.
// A load sets the count to the dwell value; the count then falls by one per
// cycle and rests at zero. expire_o is high while the count is zero, so a
// value loaded with dwell D is held for D+1 cycles before expire_o is seen.
//
// Ports:
//   clk       DDS clock
//   rst_n     asynchronous active-low reset (count cleared)
//   load_i    reload the counter from dwell_i
//   dwell_i   dwell value to load
//   expire_o  counter has reached zero
// ---------------------------------------------------------------------------
module dwell_timer #(
    parameter int DWELL_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_i,
    input  logic [DWELL_W-1:0] dwell_i,
    output logic               expire_o
);

    logic [DWELL_W-1:0] cnt_q;

    // Load / count-down register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= {DWELL_W{1'b0}};
        end else if (load_i) begin
            cnt_q <= dwell_i;
        end else if (cnt_q != {DWELL_W{1'b0}}) begin
            cnt_q <= cnt_q - {{(DWELL_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_q <= cnt_q;
        end
    end

    assign expire_o = (cnt_q == {DWELL_W{1'b0}});

endmodule

// File: rtl/freq_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// freq_sweep_ctrl
// Produces the frequency tuning word for the DDS phase accumulator. The word
// steps linearly from f_start to f_stop, each value held for dwell+1 cycles,
// in single-shot, repeating sawtooth or triangle fashion. Runs in the DDS
// clock domain so the word feeds the accumulator directly.
//
// Ports:
//   clk            DDS clock
//   rst_n          asynchronous active-low reset
//   start_i        one-cycle request: latch config and begin a sweep
//   stop_i         one-cycle request: abort (wins over start_i)
//   mode_i         00 single, 01 sawtooth, 10 triangle, 11 as single
//   f_start_i      first tuning word
//   f_stop_i       last tuning word (must be >= f_start_i)
//   f_step_i       increment per step (must be nonzero)
//   dwell_i        hold time per value minus one
//   frequency_o    registered tuning word
//   freq_upd_o     pulse when frequency_o changes or is first loaded
//   busy_o         sweep active
//   sweep_done_o   pulse at the end of each completed sweep period
//   sweep_count_o  (FREQ_SWEEP_STAT_EN only) saturating count of sweep_done
//   cfg_err_o      pulse when a start request is rejected
//
// Build option: define FREQ_SWEEP_STAT_EN to add the sweep_count_o counter.
// ---------------------------------------------------------------------------
module freq_sweep_ctrl
    import dds_pkg::*;
#(
    parameter int FTW_W   = DDS_FTW_W,
    parameter int DWELL_W = DDS_DWELL_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic               stop_i,
    input  logic [1:0]         mode_i,
    input  logic [FTW_W-1:0]   f_start_i,
    input  logic [FTW_W-1:0]   f_stop_i,
    input  logic [FTW_W-1:0]   f_step_i,
    input  logic [DWELL_W-1:0] dwell_i,
    output logic [FTW_W-1:0]   frequency_o,
    output logic               freq_upd_o,
    output logic               busy_o,
    output logic               sweep_done_o,
`ifdef FREQ_SWEEP_STAT_EN
    output logic [15:0]        sweep_count_o,
`endif
    output logic               cfg_err_o
);

    sweep_state_e       state_q;
    logic [1:0]         mode_q;
    logic [FTW_W-1:0]   fstart_q;
    logic [FTW_W-1:0]   fstop_q;
    logic [FTW_W-1:0]   fstep_q;
    logic [DWELL_W-1:0] dwell_q;
    logic [FTW_W-1:0]   freq_q;
    logic               upd_q;
    logic               busy_q;
    logic               done_q;
    logic               err_q;

    logic               cfg_ok_s;
    logic               accept_s;
    logic               reject_s;
    logic               expire_s;
    logic               step_s;
    logic               load_s;
    logic [DWELL_W-1:0] load_val_s;
    logic [FTW_W:0]     sum_s;
    logic [FTW_W:0]     down_lim_s;
    logic [FTW_W-1:0]   up_next_s;
    logic [FTW_W-1:0]   down_next_s;
    logic               at_stop_s;
    logic               at_start_s;
    logic               single_s;
    logic               bounce_s;

    // Request decoding; stop suppresses any start in the same cycle.
    always_comb begin
        cfg_ok_s = (f_step_i != {FTW_W{1'b0}}) && (f_start_i <= f_stop_i);
        accept_s = 1'b0;
        reject_s = 1'b0;
        if (start_i && !stop_i && (state_q == IDLE)) begin
            accept_s = cfg_ok_s;
            reject_s = !cfg_ok_s;
        end else begin
            accept_s = 1'b0;
            reject_s = 1'b0;
        end
    end

    // Step/clamp datapath, evaluated one bit wider so nothing wraps.
    always_comb begin
        sum_s      = {1'b0, freq_q} + {1'b0, fstep_q};
        down_lim_s = {1'b0, fstart_q} + {1'b0, fstep_q};
        up_next_s  = sum_s[FTW_W-1:0];
        down_next_s = freq_q - fstep_q;
        if (sum_s > {1'b0, fstop_q}) begin
            up_next_s = fstop_q;
        end else begin
            up_next_s = sum_s[FTW_W-1:0];
        end
        if ({1'b0, freq_q} < down_lim_s) begin
            down_next_s = fstart_q;
        end else begin
            down_next_s = freq_q - fstep_q;
        end
        at_stop_s  = (freq_q == fstop_q);
        at_start_s = (freq_q == fstart_q);
        single_s   = mode_is_single(mode_q);
        // A degenerate triangle (start == stop) has no down leg and
        // restarts like a sawtooth, giving one period per dwell.
        bounce_s   = (mode_q == MODE_TRI) && (fstart_q != fstop_q);
    end

    // Dwell control: reload on accept and on every expiry while sweeping.
    always_comb begin
        step_s     = (state_q != IDLE) && expire_s;
        load_s     = accept_s || (step_s && !stop_i);
        load_val_s = dwell_q;
        if (accept_s) begin
            load_val_s = dwell_i;
        end else begin
            load_val_s = dwell_q;
        end
    end

    dwell_timer #(
        .DWELL_W (DWELL_W)
    ) u_dwell_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (load_s),
        .dwell_i  (load_val_s),
        .expire_o (expire_s)
    );

    // Sweep FSM with registered tuning word and status pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            mode_q   <= 2'b00;
            fstart_q <= {FTW_W{1'b0}};
            fstop_q  <= {FTW_W{1'b0}};
            fstep_q  <= {FTW_W{1'b0}};
            dwell_q  <= {DWELL_W{1'b0}};
            freq_q   <= {FTW_W{1'b0}};
            upd_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            upd_q  <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (stop_i) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (accept_s) begin
                            mode_q   <= mode_i;
                            fstart_q <= f_start_i;
                            fstop_q  <= f_stop_i;
                            fstep_q  <= f_step_i;
                            dwell_q  <= dwell_i;
                            freq_q   <= f_start_i;
                            upd_q    <= 1'b1;
                            busy_q   <= 1'b1;
                            state_q  <= UP;
                        end else if (reject_s) begin
                            err_q <= 1'b1;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                    UP: begin
                        if (step_s) begin
                            if (at_stop_s) begin
                                if (single_s) begin
                                    done_q  <= 1'b1;
                                    busy_q  <= 1'b0;
                                    state_q <= IDLE;
                                end else if (bounce_s) begin
                                    state_q <= DOWN;
                                    freq_q  <= down_next_s;
                                    upd_q   <= (down_next_s != freq_q);
                                end else begin
                                    freq_q <= fstart_q;
                                    upd_q  <= (fstart_q != freq_q);
                                    done_q <= 1'b1;
                                end
                            end else begin
                                freq_q <= up_next_s;
                                upd_q  <= (up_next_s != freq_q);
                            end
                        end else begin
                            state_q <= UP;
                        end
                    end
                    DOWN: begin
                        if (step_s) begin
                            if (at_start_s) begin
                                done_q  <= 1'b1;
                                state_q <= UP;
                                freq_q  <= up_next_s;
                                upd_q   <= (up_next_s != freq_q);
                            end else begin
                                freq_q <= down_next_s;
                                upd_q  <= (down_next_s != freq_q);
                            end
                        end else begin
                            state_q <= DOWN;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef FREQ_SWEEP_STAT_EN
    logic [15:0] sweep_count_q;

    // Saturating count of completed periods, cleared by an accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sweep_count_q <= 16'h0000;
        end else if (accept_s) begin
            sweep_count_q <= 16'h0000;
        end else if (done_q && (sweep_count_q != 16'hFFFF)) begin
            sweep_count_q <= sweep_count_q + 16'h0001;
        end else begin
            sweep_count_q <= sweep_count_q;
        end
    end

    assign sweep_count_o = sweep_count_q;
`endif

    assign frequency_o  = freq_q;
    assign freq_upd_o   = upd_q;
    assign busy_o       = busy_q;
    assign sweep_done_o = done_q;
    assign cfg_err_o    = err_q;

endmodule

// File: tb/tb_freq_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// tb_freq_sweep_ctrl
// Directed scenarios with literal expectations, followed by randomized
// start/stop/config traffic. A reference model precomputes the list of
// values one sweep period visits and walks it with a dwell age counter; a
// compare process checks every output on each falling clock edge.
// Honors FREQ_SWEEP_STAT_EN for the sweep_count_o output.
// ---------------------------------------------------------------------------
module tb_freq_sweep_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start_i;
    logic        stop_i;
    logic [1:0]  mode_i;
    logic [31:0] f_start_i;
    logic [31:0] f_stop_i;
    logic [31:0] f_step_i;
    logic [15:0] dwell_i;
    logic [31:0] frequency_o;
    logic        freq_upd_o;
    logic        busy_o;
    logic        sweep_done_o;
    logic        cfg_err_o;
`ifdef FREQ_SWEEP_STAT_EN
    logic [15:0] sweep_count_o;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    freq_sweep_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start_i),
        .stop_i       (stop_i),
        .mode_i       (mode_i),
        .f_start_i    (f_start_i),
        .f_stop_i     (f_stop_i),
        .f_step_i     (f_step_i),
        .dwell_i      (dwell_i),
        .frequency_o  (frequency_o),
        .freq_upd_o   (freq_upd_o),
        .busy_o       (busy_o),
        .sweep_done_o (sweep_done_o),
`ifdef FREQ_SWEEP_STAT_EN
        .sweep_count_o(sweep_count_o),
`endif
        .cfg_err_o    (cfg_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_list[$];
    int          m_idx   = 0;
    int          m_age   = 0;
    bit          m_act   = 1'b0;
    bit          m_sup   = 1'b0;
    bit          m_acc   = 1'b0;
    bit          m_pd    = 1'b0;
    logic [1:0]  m_mode  = 2'b00;
    logic [15:0] m_dwell = 16'h0000;
    logic [31:0] m_old   = 32'h0;
    logic [31:0] e_freq  = 32'h0;
    bit          e_upd   = 1'b0;
    bit          e_busy  = 1'b0;
    bit          e_done  = 1'b0;
    bit          e_err   = 1'b0;
    logic [15:0] e_cnt   = 16'h0000;

    // Values of one period. Sawtooth/single: start .. stop, restart at index 0.
    // Triangle: first up step .. stop .. down to start; the run begins at the
    // final entry (start), and the first pass through it is not a period end.
    task automatic build(input logic [1:0] md, input longint fs, input longint fe, input longint st);
        longint v;
        m_list.delete();
        if (md == 2'b10 && fs != fe) begin
            v = fs;
            while (v != fe) begin
                v = (v + st > fe) ? fe : v + st;
                m_list.push_back(v[31:0]);
            end
            do begin
                v = (v < fs + st) ? fs : v - st;
                m_list.push_back(v[31:0]);
            end while (v != fs);
            m_idx = m_list.size() - 1;
            m_sup = 1'b1;
        end else begin
            v = fs;
            m_list.push_back(v[31:0]);
            while (v != fe) begin
                v = (v + st > fe) ? fe : v + st;
                m_list.push_back(v[31:0]);
            end
            m_idx = 0;
            m_sup = 1'b0;
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_act = 1'b0; m_idx = 0; m_age = 0; m_sup = 1'b0;
            e_freq = 32'h0; e_upd = 1'b0; e_busy = 1'b0;
            e_done = 1'b0; e_err = 1'b0; e_cnt = 16'h0000;
        end else begin
            m_pd   = e_done;
            m_acc  = 1'b0;
            e_upd  = 1'b0;
            e_done = 1'b0;
            e_err  = 1'b0;
            if (stop_i) begin
                m_act  = 1'b0;
                e_busy = 1'b0;
            end else if (!m_act) begin
                if (start_i) begin
                    if (f_step_i != 32'h0 && f_start_i <= f_stop_i) begin
                        m_mode  = mode_i;
                        m_dwell = dwell_i;
                        build(mode_i, longint'(f_start_i), longint'(f_stop_i), longint'(f_step_i));
                        e_freq = m_list[m_idx];
                        e_upd  = 1'b1;
                        e_busy = 1'b1;
                        m_act  = 1'b1;
                        m_age  = 0;
                        m_acc  = 1'b1;
                    end else begin
                        e_err = 1'b1;
                    end
                end
            end else if (m_age == int'(m_dwell)) begin
                m_age = 0;
                m_old = e_freq;
                if (m_idx == m_list.size() - 1) begin
                    if (m_mode == 2'b00 || m_mode == 2'b11) begin
                        e_done = 1'b1;
                        m_act  = 1'b0;
                        e_busy = 1'b0;
                    end else begin
                        m_idx = 0;
                        if (m_sup) m_sup = 1'b0;
                        else e_done = 1'b1;
                    end
                end else begin
                    m_idx++;
                end
                if (m_act) e_freq = m_list[m_idx];
                e_upd = (e_freq != m_old);
            end else begin
                m_age++;
            end
            if (m_acc) e_cnt = 16'h0000;
            else if (m_pd && e_cnt != 16'hFFFF) e_cnt = e_cnt + 16'h0001;
        end
    end

    // Compare process: all outputs against the model every cycle.
    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            chk("m_freq", frequency_o, e_freq);
            chk("m_upd", freq_upd_o, e_upd);
            chk("m_busy", busy_o, e_busy);
            chk("m_done", sweep_done_o, e_done);
            chk("m_err", cfg_err_o, e_err);
`ifdef FREQ_SWEEP_STAT_EN
            chk("m_count", sweep_count_o, e_cnt);
`endif
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_cfg(input logic [1:0] md, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] s, input logic [15:0] d);
        mode_i = md; f_start_i = a; f_stop_i = b; f_step_i = s; dwell_i = d;
    endtask

    task automatic gen_cfg();
        longint st, span, fs, fe;
        int sel, inv;
        logic [31:0] tmp;
        sel = $urandom_range(0, 9);
        if (sel < 6) st = longint'($urandom_range(1, 50));
        else st = longint'($urandom >> $urandom_range(0, 12)) | 64'd1;
        span = st * longint'($urandom_range(0, 5)) + (longint'($urandom) % st);
        if (span > 64'hFFFF_FFFF) span = 64'hFFFF_FFFF;
        if (sel == 9) fs = 64'hFFFF_FFFF - span;
        else fs = longint'($urandom) % (64'h1_0000_0000 - span);
        fe = fs + span;
        set_cfg(2'($urandom_range(0, 3)), fs[31:0], fe[31:0], st[31:0], 16'($urandom_range(0, 3)));
        inv = $urandom_range(0, 9);
        if (inv == 0) begin
            f_step_i = 32'h0;
        end else if (inv == 1 && span > 0) begin
            tmp = f_start_i; f_start_i = f_stop_i; f_stop_i = tmp;
        end
    endtask

    int tri_exp[14] = '{0, 4, 8, 10, 6, 2, 0, 4, 8, 10, 6, 2, 0, 4};
    int exp_v;

    initial begin
        rst_n = 1'b0; start_i = 1'b0; stop_i = 1'b0;
        set_cfg(2'b00, 32'h0, 32'h0, 32'h0, 16'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_freq", frequency_o, 32'h0);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_upd", freq_upd_o, 1'b0);
        chk("rst_done", sweep_done_o, 1'b0);
        chk("rst_err", cfg_err_o, 1'b0);

        // Single sweep 1000..1010 step 4, dwell 2
        set_cfg(2'b00, 32'd1000, 32'd1010, 32'd4, 16'd2);
        start_i = 1'b1;
        for (int k = 0; k <= 12; k++) begin
            @(negedge clk);
            start_i = 1'b0;
            if (k == 0) set_cfg(2'b10, 32'd7, 32'd9, 32'd1, 16'd0);
            exp_v = (k < 3) ? 1000 : (k < 6) ? 1004 : (k < 9) ? 1008 : 1010;
            chk("single_freq", frequency_o, 32'(exp_v));
            chk("single_busy", busy_o, k < 12);
            chk("single_done", sweep_done_o, k == 12);
            chk("single_upd", freq_upd_o, (k % 3 == 0) && (k < 12));
        end
        @(negedge clk);
        chk("single_hold", frequency_o, 32'd1010);

        // Triangle 0..10 step 4, dwell 0
        set_cfg(2'b10, 32'd0, 32'd10, 32'd4, 16'd0);
        start_i = 1'b1;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            start_i = 1'b0;
            chk("tri_freq", frequency_o, 32'(tri_exp[k]));
            chk("tri_done", sweep_done_o, (k == 7) || (k == 13));
        end
        stop_i = 1'b1;
        @(negedge clk);
        stop_i = 1'b0;
        chk("tri_stop_busy", busy_o, 1'b0);

        // Overflow clamp near the top of the range
        set_cfg(2'b00, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h10, 16'd0);
        start_i = 1'b1;
        @(negedge clk); start_i = 1'b0;
        chk("ovf_first", frequency_o, 32'hFFFF_FFF0);
        @(negedge clk);
        chk("ovf_clamp", frequency_o, 32'hFFFF_FFFF);
        @(negedge clk);
        chk("ovf_done", sweep_done_o, 1'b1);
        chk("ovf_busy", busy_o, 1'b0);
        @(negedge clk);
        chk("ovf_hold", frequency_o, 32'hFFFF_FFFF);

        // Rejected configurations
        set_cfg(2'b00, 32'd20, 32'd10, 32'd1, 16'd0);
        start_i = 1'b1;
        @(negedge clk); start_i = 1'b0;
        chk("rej1_err", cfg_err_o, 1'b1);
        chk("rej1_busy", busy_o, 1'b0);
        chk("rej1_freq", frequency_o, 32'hFFFF_FFFF);
        @(negedge clk);
        chk("rej1_pulse", cfg_err_o, 1'b0);
        set_cfg(2'b00, 32'd10, 32'd20, 32'd0, 16'd0);
        start_i = 1'b1;
        @(negedge clk); start_i = 1'b0;
        chk("rej2_err", cfg_err_o, 1'b1);
        chk("rej2_busy", busy_o, 1'b0);
        @(negedge clk);

        // Sawtooth aborted at 1008
        set_cfg(2'b01, 32'd1000, 32'd1010, 32'd4, 16'd0);
        start_i = 1'b1;
        @(negedge clk); start_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("saw_1008", frequency_o, 32'd1008);
        stop_i = 1'b1;
        @(negedge clk); stop_i = 1'b0;
        chk("abort_busy", busy_o, 1'b0);
        chk("abort_freq", frequency_o, 32'd1008);
        chk("abort_done", sweep_done_o, 1'b0);
        repeat (3) begin
            @(negedge clk);
            chk("abort_hold", frequency_o, 32'd1008);
        end

        // start and stop together in IDLE
        set_cfg(2'b00, 32'd1, 32'd2, 32'd1, 16'd0);
        start_i = 1'b1; stop_i = 1'b1;
        @(negedge clk); start_i = 1'b0; stop_i = 1'b0;
        chk("both_busy", busy_o, 1'b0);
        chk("both_freq", frequency_o, 32'd1008);
        chk("both_err", cfg_err_o, 1'b0);
        @(negedge clk);
        chk("both_busy2", busy_o, 1'b0);

`ifdef FREQ_SWEEP_STAT_EN
        // Three sawtooth periods 0,4,8 with dwell 1
        set_cfg(2'b01, 32'd0, 32'd8, 32'd4, 16'd1);
        start_i = 1'b1;
        for (int k = 0; k <= 20; k++) begin
            @(negedge clk);
            start_i = 1'b0;
            if (k == 19) chk("stat_three", sweep_count_o, 16'd3);
            if (k == 20) stop_i = 1'b1;
        end
        @(negedge clk); stop_i = 1'b0;
        chk("stat_hold", sweep_count_o, 16'd3);
        set_cfg(2'b00, 32'd5, 32'd9, 32'd2, 16'd0);
        start_i = 1'b1;
        @(negedge clk); start_i = 1'b0;
        chk("stat_clear", sweep_count_o, 16'd0);
        stop_i = 1'b1;
        @(negedge clk); stop_i = 1'b0;
`endif

        // Asynchronous reset in the middle of a dwell
        set_cfg(2'b00, 32'd1000, 32'd1010, 32'd4, 16'd5);
        start_i = 1'b1;
        @(negedge clk); start_i = 1'b0;
        @(negedge clk);
        chk("arst_pre", frequency_o, 32'd1000);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_freq", frequency_o, 32'h0);
        chk("arst_busy", busy_o, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("arst_after", frequency_o, 32'h0);

        // Randomized traffic
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            gen_cfg();
            exp_v = $urandom_range(0, 99);
            start_i = (exp_v < 4);
            stop_i  = (exp_v >= 98) || (exp_v == 3 && $urandom_range(0, 3) == 0);
        end
        @(negedge clk);
        start_i = 1'b0; stop_i = 1'b0;
        repeat (5) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
